alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Pipeline stage directly upstream of the 32-bit integer ALU.
- Takes decoded OP / OP-IMM instructions with register-file read data and builds the ALU operands (`rs_data`, `imme_rs`) and the 4-bit ALU `opcode`.
- Registers them behind a valid/ready handshake, with flush and writeback forwarding, so the ALU sees stable operands for one issued instruction at a time.

Parameters:
- XLEN, 32, operand/data width
- REG_AW, 5, register address width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- flush  input  1  discard held and incoming instruction
- in_valid  input  1  decoded instruction present
- in_ready  output  1  stage can accept this cycle
- is_imm  input  1  1 = OP-IMM (operand B = imm), 0 = OP (operand B = rs2)
- funct3  input  3  instruction funct3
- funct7_b5  input  1  instruction bit 30
- rs1_addr  input  REG_AW  source 1 index
- rs2_addr  input  REG_AW  source 2 index
- rd_addr  input  REG_AW  destination index
- rs1_rdata  input  XLEN  register-file read data, rs1
- rs2_rdata  input  XLEN  register-file read data, rs2
- imm  input  XLEN  sign-extended immediate
- wb_en  input  1  writeback write enable
- wb_rd  input  REG_AW  writeback destination
- wb_data  input  XLEN  writeback data
- out_valid  output  1  operands valid for ALU
- out_ready  input  1  downstream accepts
- rs_data  output  XLEN  ALU operand A
- imme_rs  output  XLEN  ALU operand B
- opcode  output  4  ALU operation {bit3, funct3}
- rd_out  output  REG_AW  destination carried with result

Behaviour:
- Reset (`rst`=1 at edge): `out_valid`=0; `rs_data`, `imme_rs`=0; `opcode`=0; `rd_out`=0. Holds for every cycle `rst` is high.
- Single register slot. `in_ready` = !`out_valid` || `out_ready` (combinational). Capture happens when `in_valid` && `in_ready`. Latency: 1 cycle from capture to `out_valid`.
- Transfer out when `out_valid` && `out_ready`.
  - With a simultaneous capture, the slot reloads with the new instruction and `out_valid` stays 1.
  - With no capture, `out_valid` → 0.
- While `out_valid` && !`out_ready`, all outputs hold stable. The only exception is the hold update below.
- Opcode generation: `opcode[2:0]` = `funct3`.
  - `opcode[3]` = `funct7_b5` && (`funct3`==101 || (`funct3`==000 && !`is_imm`)).
  - Bit 30 on ADDI or on any other funct3 is ignored (e.g. ADDI with bit 30 set → 0000).
- Operand B: `is_imm` ? `imm` : rs2 value. Shifts pass the full `imm`; the ALU uses bits [4:0].
- Capture forwarding: if `wb_en` && `wb_rd`==`rs1_addr` && `rs1_addr`!=0, `rs_data` captures `wb_data` instead of `rs1_rdata`. rs2 uses the same rule, applied only when !`is_imm`.
- Hold update: while holding (`out_valid` && !`out_ready`), if `wb_en` && `wb_rd`!=0 && `wb_rd` matches the held rs1 (or held rs2 when OP), the corresponding operand register updates to `wb_data`.
  - Held rs1/rs2 addresses and the held `is_imm` are stored internally.
- x0: never forwarded. Register file supplies 0.
- Flush: at the clock edge `out_valid` → 0 and no capture occurs, even if `in_valid`. `in_ready` is still computed normally. Data registers need not clear.
- Flush has priority over capture and hold update. `rst` has priority over everything.

Optional Feature:
- Macro: ALU_ISSUE_FWD_EN.
- Defined: capture forwarding and hold-update forwarding as above.
- Not defined: no forwarding logic; operands are taken from `rs1_rdata`/`rs2_rdata` only. The held slot is never modified while stalled. The `wb_*` ports remain present but unused.

Test Plan:
- Reset, then ADD (OP, `funct3`=000, bit30=0): rs1=5, rs2=7 → next cycle `out_valid`=1, `rs_data`=5, `imme_rs`=7, `opcode`=0000, `rd_out` as issued.
- SUB (OP, 000, bit30=1) → `opcode`=1000. SRAI (OP-IMM, 101, bit30=1, `imm`=0x403) → `opcode`=1101, `imme_rs`=0x403. ADDI with bit30=1 → `opcode`=0000, `imme_rs`=`imm`.
- Backpressure: `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, outputs stable. `out_ready`=1 → transfer and new capture in the same cycle, `out_valid` stays 1.
- FWD_EN: capture rs1=x3 with `rs1_rdata`=0x11 while `wb_en`=1, `wb_rd`=3, `wb_data`=0xAA → `rs_data`=0xAA. Same with `wb_rd`=0 → 0x11. Stalled OP holding rs2=x4, writeback x4=0x55 → `imme_rs` becomes 0x55. OP-IMM held, writeback to rs2 index → `imme_rs` unchanged.
- Flush with `out_valid`=1 and `in_valid`=1 → next cycle `out_valid`=0, nothing captured. `rst` asserted while holding a valid entry → `out_valid`=0 and all outputs 0 next cycle.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// Handshake and operand bus between the decode side, the writeback port and the ALU.
// master = environment driving decoded instructions; slave = alu_issue_stage.
interface alu_issue_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              is_imm;
  logic [2:0]        funct3;
  logic              funct7_b5;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [REG_AW-1:0] rd_addr;
  logic [XLEN-1:0]   rs1_rdata;
  logic [XLEN-1:0]   rs2_rdata;
  logic [XLEN-1:0]   imm;
  logic              wb_en;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   rs_data;
  logic [XLEN-1:0]   imme_rs;
  logic [3:0]        opcode;
  logic [REG_AW-1:0] rd_out;

  modport master (
    output flush, in_valid, is_imm, funct3, funct7_b5,
           rs1_addr, rs2_addr, rd_addr, rs1_rdata, rs2_rdata, imm,
           wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, rs_data, imme_rs, opcode, rd_out
  );

  modport slave (
    input  flush, in_valid, is_imm, funct3, funct7_b5,
           rs1_addr, rs2_addr, rd_addr, rs1_rdata, rs2_rdata, imm,
           wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, rs_data, imme_rs, opcode, rd_out
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Single-slot issue register in front of the integer ALU: builds operands and opcode.
// Define ALU_ISSUE_FWD_EN to enable writeback forwarding at capture and while stalled.
module alu_issue_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_stage_if.slave  bus
);

  logic              r_valid;
  logic [XLEN-1:0]   r_rs_data;
  logic [XLEN-1:0]   r_imme_rs;
  logic [3:0]        r_opcode;
  logic [REG_AW-1:0] r_rd;

  logic              w_in_ready;
  logic              w_capture;
  logic              w_opc_b3;
  logic [XLEN-1:0]   w_op_a;
  logic [XLEN-1:0]   w_rs2_val;
  logic [XLEN-1:0]   w_op_b;

  assign w_in_ready = !r_valid || bus.out_ready;
  assign w_capture  = bus.in_valid && w_in_ready;

  // Bit 30 only selects SUB (OP add slot) or arithmetic right shift.
  assign w_opc_b3 = bus.funct7_b5 &&
                    ((bus.funct3 == 3'b101) || ((bus.funct3 == 3'b000) && !bus.is_imm));

`ifdef ALU_ISSUE_FWD_EN
  logic [REG_AW-1:0] r_rs1_addr;
  logic [REG_AW-1:0] r_rs2_addr;
  logic              r_is_imm;
  logic              w_fwd_rs1;
  logic              w_fwd_rs2;
  logic              w_hold;
  logic              w_hold_a;
  logic              w_hold_b;

  assign w_fwd_rs1 = bus.wb_en && (bus.wb_rd == bus.rs1_addr) && (bus.rs1_addr != '0);
  assign w_fwd_rs2 = bus.wb_en && (bus.wb_rd == bus.rs2_addr) && (bus.rs2_addr != '0);
  assign w_op_a    = w_fwd_rs1 ? bus.wb_data : bus.rs1_rdata;
  assign w_rs2_val = w_fwd_rs2 ? bus.wb_data : bus.rs2_rdata;

  // A stalled entry keeps tracking late writebacks to its sources.
  assign w_hold   = r_valid && !bus.out_ready;
  assign w_hold_a = w_hold && bus.wb_en && (bus.wb_rd != '0) && (bus.wb_rd == r_rs1_addr);
  assign w_hold_b = w_hold && bus.wb_en && (bus.wb_rd != '0) && !r_is_imm &&
                    (bus.wb_rd == r_rs2_addr);
`else
  assign w_op_a    = bus.rs1_rdata;
  assign w_rs2_val = bus.rs2_rdata;
`endif

  assign w_op_b = bus.is_imm ? bus.imm : w_rs2_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_rs_data <= '0;
      r_imme_rs <= '0;
      r_opcode  <= '0;
      r_rd      <= '0;
`ifdef ALU_ISSUE_FWD_EN
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_is_imm   <= 1'b0;
`endif
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid   <= 1'b1;
      r_rs_data <= w_op_a;
      r_imme_rs <= w_op_b;
      r_opcode  <= {w_opc_b3, bus.funct3};
      r_rd      <= bus.rd_addr;
`ifdef ALU_ISSUE_FWD_EN
      r_rs1_addr <= bus.rs1_addr;
      r_rs2_addr <= bus.rs2_addr;
      r_is_imm   <= bus.is_imm;
`endif
    end else begin
      r_valid <= r_valid && !bus.out_ready;
`ifdef ALU_ISSUE_FWD_EN
      if (w_hold_a) r_rs_data <= bus.wb_data;
      if (w_hold_b) r_imme_rs <= bus.wb_data;
`endif
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.rs_data   = r_rs_data;
  assign bus.imme_rs   = r_imme_rs;
  assign bus.opcode    = r_opcode;
  assign bus.rd_out    = r_rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus randomized traffic
// against a behavioural model of the issue slot.
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_issue_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

  alu_issue_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural model of the single slot.
  bit        m_valid;
  bit        m_was_rst;
  bit [31:0] m_a, m_b;
  bit [3:0]  m_opc;
  bit [4:0]  m_rd, m_a1, m_a2;
  bit        m_imm;

  function automatic bit [31:0] src_val(input bit [4:0] a, input bit [31:0] rf);
    if (FWD && bus.wb_en && a != 0 && bus.wb_rd == a) return bus.wb_data;
    return rf;
  endfunction

  task automatic mdl_update();
    bit rdy;
    rdy = !m_valid || bus.out_ready;
    m_was_rst = rst;
    if (rst) begin
      m_valid = 0; m_a = 0; m_b = 0; m_opc = 0; m_rd = 0; m_a1 = 0; m_a2 = 0; m_imm = 0;
    end else if (bus.flush) begin
      m_valid = 0;
    end else if (bus.in_valid && rdy) begin
      m_valid = 1;
      m_a     = src_val(bus.rs1_addr, bus.rs1_rdata);
      m_b     = bus.is_imm ? bus.imm : src_val(bus.rs2_addr, bus.rs2_rdata);
      m_opc[2:0] = bus.funct3;
      m_opc[3]   = bus.funct7_b5 && (bus.funct3 == 5 || (bus.funct3 == 0 && !bus.is_imm));
      m_rd  = bus.rd_addr;
      m_a1  = bus.rs1_addr;
      m_a2  = bus.rs2_addr;
      m_imm = bus.is_imm;
    end else if (m_valid && bus.out_ready) begin
      m_valid = 0;
    end else if (m_valid && FWD && bus.wb_en && bus.wb_rd != 0) begin
      if (bus.wb_rd == m_a1) m_a = bus.wb_data;
      if (!m_imm && bus.wb_rd == m_a2) m_b = bus.wb_data;
    end
  endtask

  task automatic step();
    mdl_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_instr(input bit imm_sel, input bit [2:0] f3, input bit b5,
                             input bit [4:0] a1, input bit [4:0] a2, input bit [4:0] rd,
                             input bit [31:0] d1, input bit [31:0] d2, input bit [31:0] im);
    bus.in_valid  = 1'b1;
    bus.is_imm    = imm_sel;
    bus.funct3    = f3;
    bus.funct7_b5 = b5;
    bus.rs1_addr  = a1;
    bus.rs2_addr  = a2;
    bus.rd_addr   = rd;
    bus.rs1_rdata = d1;
    bus.rs2_rdata = d2;
    bus.imm       = im;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flush = 0; bus.in_valid = 1; bus.out_ready = 0; bus.wb_en = 0; bus.wb_rd = 0;
    bus.wb_data = 0;
    drive_instr(0, 3'b000, 0, 1, 2, 3, 32'h1, 32'h2, 32'h0);
    step();
    step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.rs_data !== 32'h0) begin n_err++; $display("FAIL reset_rs_data got=%h exp=0", bus.rs_data); end
    n_cmp++; if (bus.imme_rs !== 32'h0) begin n_err++; $display("FAIL reset_imme_rs got=%h exp=0", bus.imme_rs); end
    n_cmp++; if (bus.opcode !== 4'h0) begin n_err++; $display("FAIL reset_opcode got=%h exp=0", bus.opcode); end
    n_cmp++; if (bus.rd_out !== 5'h0) begin n_err++; $display("FAIL reset_rd got=%h exp=0", bus.rd_out); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    rst = 1'b0;
    bus.in_valid = 0;
    step();
    $display("test_reset done");
  endtask

  task automatic test_alu_ops();
    bus.out_ready = 1;
    drive_instr(0, 3'b000, 0, 1, 2, 9, 32'd5, 32'd7, 32'h0);
    step();
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got=%b exp=1", bus.out_valid); end
    n_cmp++; if (bus.rs_data !== 32'd5) begin n_err++; $display("FAIL add_rs_data got=%h exp=5", bus.rs_data); end
    n_cmp++; if (bus.imme_rs !== 32'd7) begin n_err++; $display("FAIL add_imme_rs got=%h exp=7", bus.imme_rs); end
    n_cmp++; if (bus.opcode !== 4'b0000) begin n_err++; $display("FAIL add_opcode got=%b exp=0000", bus.opcode); end
    n_cmp++; if (bus.rd_out !== 5'd9) begin n_err++; $display("FAIL add_rd got=%0d exp=9", bus.rd_out); end
    $display("ADD  rs=%h b=%h opc=%b", bus.rs_data, bus.imme_rs, bus.opcode);
    drive_instr(0, 3'b000, 1, 1, 2, 10, 32'd9, 32'd4, 32'h0);
    step();
    n_cmp++; if (bus.opcode !== 4'b1000) begin n_err++; $display("FAIL sub_opcode got=%b exp=1000", bus.opcode); end
    $display("SUB  rs=%h b=%h opc=%b", bus.rs_data, bus.imme_rs, bus.opcode);
    drive_instr(1, 3'b101, 1, 1, 3, 11, 32'h80000000, 32'hDEAD, 32'h403);
    step();
    n_cmp++; if (bus.opcode !== 4'b1101) begin n_err++; $display("FAIL srai_opcode got=%b exp=1101", bus.opcode); end
    n_cmp++; if (bus.imme_rs !== 32'h403) begin n_err++; $display("FAIL srai_imme_rs got=%h exp=403", bus.imme_rs); end
    $display("SRAI rs=%h b=%h opc=%b", bus.rs_data, bus.imme_rs, bus.opcode);
    drive_instr(1, 3'b000, 1, 1, 0, 12, 32'h10, 32'hBEEF, 32'hFFFFF123);
    step();
    n_cmp++; if (bus.opcode !== 4'b0000) begin n_err++; $display("FAIL addi_opcode got=%b exp=0000", bus.opcode); end
    n_cmp++; if (bus.imme_rs !== 32'hFFFFF123) begin n_err++; $display("FAIL addi_imme_rs got=%h exp=fffff123", bus.imme_rs); end
    $display("ADDI rs=%h b=%h opc=%b", bus.rs_data, bus.imme_rs, bus.opcode);
    bus.in_valid = 0;
    step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1;
    drive_instr(0, 3'b100, 0, 1, 2, 20, 32'hA1, 32'hA2, 32'h0);
    step();
    bus.out_ready = 0;
    drive_instr(0, 3'b110, 0, 3, 4, 21, 32'hB1, 32'hB2, 32'h0);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.rd_out !== 5'd20 || bus.rs_data !== 32'hA1 ||
          bus.imme_rs !== 32'hA2 || bus.opcode !== 4'b0100) begin
        n_err++;
        $display("FAIL bp_hold%0d got v=%b rd=%0d a=%h b=%h op=%b exp v=1 rd=20 a=a1 b=a2 op=0100",
                 k, bus.out_valid, bus.rd_out, bus.rs_data, bus.imme_rs, bus.opcode);
      end
      $display("stall %0d rd=%0d", k, bus.rd_out);
    end
    bus.out_ready = 1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.rd_out !== 5'd21 || bus.rs_data !== 32'hB1) begin
      n_err++;
      $display("FAIL bp_reload got v=%b rd=%0d a=%h exp v=1 rd=21 a=b1", bus.out_valid, bus.rd_out, bus.rs_data);
    end
    bus.in_valid = 0;
    step();
  endtask

  task automatic test_forwarding();
    bus.out_ready = 1;
    bus.wb_en = 1; bus.wb_rd = 3; bus.wb_data = 32'hAA;
    drive_instr(0, 3'b000, 0, 3, 5, 12, 32'h11, 32'h22, 32'h0);
    step();
    n_cmp++; if (bus.rs_data !== (FWD ? 32'hAA : 32'h11)) begin n_err++; $display("FAIL fwd_cap_rs1 got=%h exp=%h", bus.rs_data, FWD ? 32'hAA : 32'h11); end
    n_cmp++; if (bus.imme_rs !== 32'h22) begin n_err++; $display("FAIL fwd_cap_rs2 got=%h exp=22", bus.imme_rs); end
    bus.wb_rd = 0;
    step();
    n_cmp++; if (bus.rs_data !== 32'h11) begin n_err++; $display("FAIL fwd_wbrd0 got=%h exp=11", bus.rs_data); end
    bus.wb_en = 0;
    drive_instr(0, 3'b000, 0, 6, 4, 13, 32'h60, 32'h44, 32'h0);
    step();
    bus.out_ready = 0; bus.in_valid = 0;
    bus.wb_en = 1; bus.wb_rd = 4; bus.wb_data = 32'h55;
    step();
    n_cmp++; if (bus.imme_rs !== (FWD ? 32'h55 : 32'h44)) begin n_err++; $display("FAIL hold_rs2 got=%h exp=%h", bus.imme_rs, FWD ? 32'h55 : 32'h44); end
    bus.wb_rd = 6; bus.wb_data = 32'h66;
    step();
    n_cmp++; if (bus.rs_data !== (FWD ? 32'h66 : 32'h60)) begin n_err++; $display("FAIL hold_rs1 got=%h exp=%h", bus.rs_data, FWD ? 32'h66 : 32'h60); end
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid got=%b exp=1", bus.out_valid); end
    bus.wb_en = 0; bus.out_ready = 1;
    drive_instr(1, 3'b000, 0, 7, 8, 14, 32'h70, 32'h80, 32'h7FF);
    step();
    bus.out_ready = 0; bus.in_valid = 0;
    bus.wb_en = 1; bus.wb_rd = 8; bus.wb_data = 32'h88;
    step();
    n_cmp++; if (bus.imme_rs !== 32'h7FF) begin n_err++; $display("FAIL hold_opimm_b got=%h exp=7ff", bus.imme_rs); end
    $display("forwarding checks done (fwd=%0d)", FWD);
    bus.wb_en = 0; bus.out_ready = 1;
    step();
  endtask

  task automatic test_flush();
    bus.out_ready = 1;
    drive_instr(0, 3'b001, 0, 1, 2, 15, 32'h1, 32'h2, 32'h0);
    step();
    bus.out_ready = 0; bus.flush = 1;
    drive_instr(0, 3'b010, 0, 1, 2, 16, 32'h3, 32'h4, 32'h0);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got=%b exp=0", bus.in_ready); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got=%b exp=0", bus.out_valid); end
    bus.out_ready = 1;
    step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_nocap got=%b exp=0", bus.out_valid); end
    bus.flush = 0; bus.in_valid = 0;
    step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_after got=%b exp=0", bus.out_valid); end
    $display("flush checks done");
  endtask

  task automatic test_reset_hold();
    bus.out_ready = 1;
    drive_instr(1, 3'b111, 0, 9, 10, 17, 32'h99, 32'h0, 32'h123);
    step();
    bus.out_ready = 0; bus.in_valid = 0;
    step();
    rst = 1;
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.rs_data !== 32'h0 || bus.imme_rs !== 32'h0 ||
        bus.opcode !== 4'h0 || bus.rd_out !== 5'h0) begin
      n_err++;
      $display("FAIL rst_hold got v=%b a=%h b=%h op=%h rd=%0d exp all 0",
               bus.out_valid, bus.rs_data, bus.imme_rs, bus.opcode, bus.rd_out);
    end
    rst = 0;
    step();
    $display("reset-while-holding done");
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      rst           = ($urandom_range(0, 99) < 2);
      bus.flush     = ($urandom_range(0, 99) < 5);
      bus.in_valid  = ($urandom_range(0, 99) < 70);
      bus.out_ready = ($urandom_range(0, 99) < 60);
      bus.is_imm    = $urandom_range(0, 1);
      bus.funct3    = $urandom_range(0, 7);
      bus.funct7_b5 = $urandom_range(0, 1);
      bus.rs1_addr  = $urandom_range(0, 7);
      bus.rs2_addr  = $urandom_range(0, 7);
      bus.rd_addr   = $urandom_range(0, 31);
      bus.rs1_rdata = $urandom;
      bus.rs2_rdata = $urandom;
      bus.imm       = $urandom;
      bus.wb_en     = $urandom_range(0, 1);
      bus.wb_rd     = $urandom_range(0, 7);
      bus.wb_data   = $urandom;
      #1;
      n_cmp++;
      if (bus.in_ready !== (!m_valid || bus.out_ready)) begin
        n_err++;
        $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", c, bus.in_ready, !m_valid || bus.out_ready);
      end
      step();
      n_cmp++;
      if (bus.out_valid !== m_valid) begin
        n_err++;
        $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, bus.out_valid, m_valid);
      end
      if (m_valid || m_was_rst) begin
        n_cmp++;
        if (bus.rs_data !== m_a || bus.imme_rs !== m_b || bus.opcode !== m_opc || bus.rd_out !== m_rd) begin
          n_err++;
          $display("FAIL rnd_data cyc=%0d got a=%h b=%h op=%h rd=%0d exp a=%h b=%h op=%h rd=%0d",
                   c, bus.rs_data, bus.imme_rs, bus.opcode, bus.rd_out, m_a, m_b, m_opc, m_rd);
        end
      end
    end
    rst = 0;
    $display("random traffic done");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_ops();
    test_backpressure();
    test_forwarding();
    test_flush();
    test_reset_hold();
    test_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
